// File: rtl/agc_probit_pkg.sv
// Shared constants, state encoding and width helper for the AGC probit sequencer.
// The optional PROBIT_SEQ_AUTORESTART_EN build adds back-to-back integrations in the top.
package agc_probit_pkg;

    localparam int PROBIT_LANES  = 8;
    localparam int DEFAULT_NBITS = 21;

    // Largest period field whose full-length integration still fits below the sum MSB.
    function automatic int nclkBitsFor(input int nbits);
        return nbits - 1 - $clog2(PROBIT_LANES);
    endfunction

    localparam int DEFAULT_NCLK_BITS = nclkBitsFor(DEFAULT_NBITS);

    typedef logic [1:0] probit_state_t;

    localparam probit_state_t ST_IDLE    = 2'd0;
    localparam probit_state_t ST_CLEAR   = 2'd1;
    localparam probit_state_t ST_RUN     = 2'd2;
    localparam probit_state_t ST_CAPTURE = 2'd3;

endpackage

// File: rtl/agc_probit_period_counter.sv
// Loadable down-counter with a zero flag; paces the RUN phase of the probit sequencer.
module agc_probit_period_counter
    import agc_probit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_NCLK_BITS
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             dec_i,
    input  logic [WIDTH-1:0] value_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_count <= '0;
        end else if (load_i) begin
            r_count <= value_i;
        end else if (dec_i) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign zero_o = (r_count == '0);

endmodule

// File: rtl/agc_probit_sequencer.sv
// Clear/enable sequencer and result capture for one gt/lt probit accumulator pair.
// Optional macro PROBIT_SEQ_AUTORESTART_EN adds continuous_i for back-to-back integrations.
module agc_probit_sequencer
    import agc_probit_pkg::*;
#(
    parameter int    NBITS     = DEFAULT_NBITS,
    parameter int    NCLK_BITS = DEFAULT_NCLK_BITS,
    parameter string CLKTYPE   = "NONE"
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic [NCLK_BITS-1:0] period_i,
`ifdef PROBIT_SEQ_AUTORESTART_EN
    input  logic                 continuous_i,
`endif
    output logic                 busy_o,
    output logic                 acc_rst_o,
    output logic                 acc_ce_o,
    input  logic [NBITS-1:0]     gt_sum_i,
    input  logic [NBITS-1:0]     lt_sum_i,
    output logic [NBITS-1:0]     gt_count_o,
    output logic [NBITS-1:0]     lt_count_o,
    output logic                 valid_o,
    input  logic                 ack_i,
    output logic                 overrun_o
);

    probit_state_t        r_state;
    probit_state_t        w_nextState;
    logic [NCLK_BITS-1:0] r_periodQ;
    logic                 r_accRst;
    logic                 r_accCe;
    logic                 r_busy;
    logic                 w_zero;
    logic                 w_continue;

    (* CUSTOM_CC_SRC = CLKTYPE *) logic [NBITS-1:0] r_gtCount;
    (* CUSTOM_CC_SRC = CLKTYPE *) logic [NBITS-1:0] r_ltCount;
    (* CUSTOM_CC_SRC = CLKTYPE *) logic             r_valid;
    logic                                           r_overrun;

`ifdef PROBIT_SEQ_AUTORESTART_EN
    assign w_continue = continuous_i;
`else
    assign w_continue = 1'b0;
`endif

    agc_probit_period_counter #(
        .WIDTH   (NCLK_BITS)
    ) u_periodCounter (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (r_state == ST_CLEAR),
        .dec_i   ((r_state == ST_RUN) && !w_zero),
        .value_i (r_periodQ),
        .zero_o  (w_zero)
    );

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE:    if (start_i) w_nextState = ST_CLEAR;
            ST_CLEAR:   w_nextState = abort_i ? ST_IDLE : ST_RUN;
            ST_RUN: begin
                if (abort_i)     w_nextState = ST_IDLE;
                else if (w_zero) w_nextState = ST_CAPTURE;
            end
            ST_CAPTURE: w_nextState = w_continue ? ST_CLEAR : ST_IDLE;
            default:    w_nextState = ST_IDLE;
        endcase
    end

    // Strobes are registered from the next state so they line up exactly with CLEAR/RUN.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= ST_IDLE;
            r_periodQ <= '0;
            r_accRst  <= 1'b1;
            r_accCe   <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state  <= w_nextState;
            r_accRst <= (w_nextState == ST_CLEAR);
            r_accCe  <= (w_nextState == ST_RUN);
            r_busy   <= (w_nextState != ST_IDLE);
            if ((r_state == ST_IDLE) && start_i) begin
                r_periodQ <= period_i;
            end
        end
    end

    // A capture in the same cycle as ack wins, so an acknowledged old result never counts as overrun.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_gtCount <= '0;
            r_ltCount <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else if (r_state == ST_CAPTURE) begin
            r_gtCount <= gt_sum_i;
            r_ltCount <= lt_sum_i;
            r_valid   <= 1'b1;
            if (r_valid && !ack_i) begin
                r_overrun <= 1'b1;
            end
        end else if (ack_i) begin
            r_valid <= 1'b0;
        end
    end

    assign busy_o     = r_busy;
    assign acc_rst_o  = r_accRst;
    assign acc_ce_o   = r_accCe;
    assign gt_count_o = r_gtCount;
    assign lt_count_o = r_ltCount;
    assign valid_o    = r_valid;
    assign overrun_o  = r_overrun;

endmodule

// File: tb/tb_agc_probit_sequencer.sv
// Randomized directed bench for agc_probit_sequencer with a window-based result model.
// Exercises continuous_i only when PROBIT_SEQ_AUTORESTART_EN is defined.
module tb_agc_probit_sequencer;

    localparam int NBITS     = 14;
    localparam int NCLK_BITS = 10;

    logic                 clk = 1'b0;
    logic                 rst_i = 1'b1;
    logic                 start_i = 1'b0;
    logic                 abort_i = 1'b0;
    logic                 ack_i = 1'b0;
    logic [NCLK_BITS-1:0] period_i = '0;
`ifdef PROBIT_SEQ_AUTORESTART_EN
    logic                 continuous_i = 1'b0;
`endif
    logic                 busy, accRst, accCe, valid, overrun;
    logic [NBITS-1:0]     gtSum, ltSum, gtCount, ltCount;

    int gtPop = 0;
    int ltPop = 0;
    int total = 0;
    int bad = 0;
    bit expValid = 1'b0;
    bit expOverrun = 1'b0;
    int expGt = 0;
    int expLt = 0;

    always #5 clk = ~clk;

    agc_probit_sequencer #(
        .NBITS      (NBITS),
        .NCLK_BITS  (NCLK_BITS),
        .CLKTYPE    ("NONE")
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .abort_i      (abort_i),
        .period_i     (period_i),
`ifdef PROBIT_SEQ_AUTORESTART_EN
        .continuous_i (continuous_i),
`endif
        .busy_o       (busy),
        .acc_rst_o    (accRst),
        .acc_ce_o     (accCe),
        .gt_sum_i     (gtSum),
        .lt_sum_i     (ltSum),
        .gt_count_o   (gtCount),
        .lt_count_o   (ltCount),
        .valid_o      (valid),
        .ack_i        (ack_i),
        .overrun_o    (overrun)
    );

    // Accumulator stand-in: adds the per-clock lane popcounts while enabled.
    always @(posedge clk) begin
        if (accRst) begin
            gtSum <= '0;
            ltSum <= '0;
        end else if (accCe) begin
            gtSum <= gtSum + NBITS'(gtPop);
            ltSum <= ltSum + NBITS'(ltPop);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic setPops(input bit allOnes);
        if (allOnes) begin
            gtPop = 8;
            ltPop = 0;
        end else begin
            gtPop = int'($urandom_range(0, 8));
            ltPop = int'($urandom_range(0, 8 - gtPop));
        end
    endtask

    task automatic checkResult();
        checkOutput("valid", valid, expValid);
        checkOutput("overrun", overrun, expOverrun);
        checkOutput("gt_count", gtCount, expGt);
        checkOutput("lt_count", ltCount, expLt);
    endtask

    // One integration from start; abortK >= 0 cancels it at that cycle index.
    task automatic applyStimulus(input int p, input int abortK, input bit ackAtCap, input bit allOnes);
        int accGt = 0;
        int accLt = 0;
        bit aborted = (abortK >= 0);
        int lastBusy = aborted ? abortK : p + 3;
        int lastCe = aborted ? abortK : p + 2;
        int kEnd = lastBusy + 1;
        start_i  = 1'b1;
        period_i = NCLK_BITS'(p);
        abort_i  = 1'b0;
        ack_i    = 1'b0;
        setPops(allOnes);
        for (int k = 1; k <= kEnd; k++) begin
            @(posedge clk);
            #1;
            if (!aborted && k == p + 4) begin
                expOverrun = expOverrun | (expValid & ~ackAtCap);
                expValid   = 1'b1;
                expGt      = accGt;
                expLt      = accLt;
            end
            checkOutput("acc_rst", accRst, (k == 1));
            checkOutput("acc_ce", accCe, (k >= 2 && k <= lastCe));
            checkOutput("busy", busy, (k <= lastBusy));
            checkOutput("valid", valid, expValid);
            start_i = (k <= lastBusy) ? 1'($urandom_range(0, 1)) : 1'b0;
            abort_i = (k == abortK);
            ack_i   = ackAtCap && !aborted && (k == p + 3);
            setPops(allOnes);
            if (!aborted && k >= 2 && k <= p + 2) begin
                accGt += gtPop;
                accLt += ltPop;
            end
        end
        start_i = 1'b0;
        abort_i = 1'b0;
        ack_i   = 1'b0;
        checkResult();
    endtask

    task automatic ackResult();
        ack_i = 1'b1;
        @(posedge clk);
        #1;
        ack_i    = 1'b0;
        expValid = 1'b0;
        checkResult();
    endtask

    initial begin
        $display("[TB] start");
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset acc_rst", accRst, 1);
        checkOutput("reset acc_ce", accCe, 0);
        checkOutput("reset busy", busy, 0);
        checkResult();
        rst_i = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("idle acc_rst", accRst, 0);

        applyStimulus(3, -1, 1'b0, 1'b1);
        checkOutput("p3 gt=32", gtCount, 32);
        ackResult();
        applyStimulus(0, -1, 1'b0, 1'b1);
        checkOutput("p0 gt=8", gtCount, 8);
        ackResult();
        ackResult();
        applyStimulus(int'($urandom_range(1, 20)), -1, 1'b0, 1'b0);
        ackResult();

        applyStimulus(9, 3, 1'b0, 1'b0);
        applyStimulus(1, -1, 1'b0, 1'b0);
        applyStimulus(4, -1, 1'b1, 1'b0);
        checkOutput("ack at capture no overrun", overrun, 0);
        applyStimulus(2, -1, 1'b0, 1'b0);
        checkOutput("overrun set", overrun, 1);
        ackResult();

        // Reset during RUN cycle 40 of a 101-clock integration.
        start_i  = 1'b1;
        period_i = NCLK_BITS'(100);
        for (int k = 1; k <= 41; k++) begin
            @(posedge clk);
            #1;
            start_i = 1'b0;
        end
        checkOutput("mid-run acc_ce", accCe, 1);
        rst_i = 1'b1;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        expValid = 1'b0;
        expOverrun = 1'b0;
        expGt = 0;
        expLt = 0;
        checkOutput("mid reset acc_rst", accRst, 1);
        checkOutput("mid reset acc_ce", accCe, 0);
        checkOutput("mid reset busy", busy, 0);
        checkResult();
        rst_i = 1'b0;
        start_i = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("post reset acc_rst", accRst, 0);
        checkOutput("post reset busy", busy, 0);

        applyStimulus((1 << NCLK_BITS) - 1, -1, 1'b0, 1'b1);
        checkOutput("max period no wrap", gtCount, 1 << (NBITS - 1));
        ackResult();

        for (int i = 0; i < 4; i++) begin
            applyStimulus(int'($urandom_range(0, 30)), -1, 1'($urandom_range(0, 1)), 1'b0);
            if ($urandom_range(0, 1) == 1) ackResult();
        end

`ifdef PROBIT_SEQ_AUTORESTART_EN
        continuous_i = 1'b1;
        start_i      = 1'b1;
        period_i     = NCLK_BITS'(3);
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk);
            #1;
            start_i = 1'b0;
            checkOutput("cont acc_rst", accRst, (k <= 15) && (k % 6 == 1));
            checkOutput("cont acc_ce", accCe, (k <= 15) && (k % 6 >= 2) && (k % 6 <= 5));
            checkOutput("cont busy", busy, (k <= 15));
            abort_i = (k == 15);
        end
        abort_i      = 1'b0;
        continuous_i = 1'b0;
        checkOutput("cont valid", valid, 1);
        checkOutput("cont overrun", overrun, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/agc_probit_sequencer.md
Name: agc_probit_sequencer

Overview:
Controls one pair of 8-lane probit (gt/lt) accumulators in the AGC path.
- Drives the accumulator's synchronous clear and clock-enable so that it integrates over exactly the programmed number of clocks.
- Captures the final gt/lt sums into holding registers and presents them to the AGC/register side with a valid/ack handshake.
- Sits between the AGC control register block and the probit accumulator instance.

Parameters:
NBITS, 21, width of the accumulator sums. Must equal log2(max samples)+1, at 8 samples per clock.
NCLK_BITS, 17, width of the period field. Max period is 2^NCLK_BITS clocks; 8·2^NCLK_BITS must be ≤ 2^(NBITS-1).
CLKTYPE, "NONE", value placed in the CUSTOM_CC_SRC attribute on the capture registers and on valid_o.

Ports:
clk_i  in  1  sole clock
rst_i  in  1  synchronous active-high reset
start_i  in  1  single-cycle pulse: begin one integration
abort_i  in  1  single-cycle pulse: cancel integration in progress
period_i  in  NCLK_BITS  integration length in clocks, minus 1; sampled on accepted start
busy_o  out  1  high from accepted start through capture
acc_rst_o  out  1  to accumulator rst_i
acc_ce_o  out  1  to accumulator ce_i
gt_sum_i  in  NBITS  from accumulator gt_sum_o
lt_sum_i  in  NBITS  from accumulator lt_sum_o
gt_count_o  out  NBITS  captured gt total
lt_count_o  out  NBITS  captured lt total
valid_o  out  1  capture registers hold an unacknowledged result
ack_i  in  1  consumer accepts result; clears valid_o
overrun_o  out  1  sticky: a capture occurred while valid_o was already high; cleared only by rst_i

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - state=IDLE.
  - busy_o=0, acc_ce_o=0, valid_o=0, overrun_o=0.
  - gt_count_o=lt_count_o=0, internal counter=0.
  - acc_rst_o=1 during reset, so the accumulator is cleared together with the sequencer.
  - Reset mid-integration discards the integration entirely.
- acc_rst_o and acc_ce_o are registered outputs and are never high in the same cycle.
- States: IDLE, CLEAR, RUN, CAPTURE.
- IDLE:
  - start_i=1 latches period_i into period_q and goes to CLEAR.
  - start_i is ignored in every other state; no queuing.
- CLEAR:
  - Exactly one cycle with acc_rst_o=1.
  - Load counter=period_q, then go to RUN.
- RUN:
  - acc_ce_o=1 every cycle.
  - Counter decrements each cycle. At counter==0 go to CAPTURE.
  - So acc_ce_o is high for exactly period_q+1 contiguous cycles.
  - period_i=0 gives a 1-clock (8-sample) integration.
- CAPTURE (one cycle, acc_ce_o=0):
  - Latch gt_sum_i and lt_sum_i into gt_count_o and lt_count_o.
  - Set valid_o. If valid_o was already 1 and ack_i is not 1 this cycle, set overrun_o.
  - Return to IDLE.
- Latency from accepted start to valid_o=1 is period_q+3 clocks: 1 CLEAR + (period_q+1) RUN + 1 CAPTURE; valid_o is visible the clock after CAPTURE.
- busy_o is 1 in CLEAR, RUN and CAPTURE.
- The accumulator's input compressors run freely. The sequencer gates only the accumulator ce; it never stalls the data.
- Handshake:
  - valid_o stays high until ack_i=1; valid_o clears on the next clock.
  - gt_count_o and lt_count_o hold their values until the next CAPTURE.
  - ack_i while valid_o=0 is ignored.
  - ack_i in the same cycle as CAPTURE: the new capture wins, valid_o stays 1, no overrun.
- abort_i:
  - In CLEAR or RUN: go to IDLE next clock, acc_ce_o=0, no capture, valid_o, count registers and overrun_o untouched.
  - Ignored in IDLE and CAPTURE.
  - abort_i and start_i together in IDLE: start wins.
- Width rule: at most 8·(period_q+1) ≤ 2^(NBITS-1), so the sums cannot wrap. No saturation logic is required.

Optional Feature:
Macro PROBIT_SEQ_AUTORESTART_EN.
- Defined:
  - Adds input continuous_i (1 bit).
  - When continuous_i=1, CAPTURE goes directly to CLEAR using the same period_q, giving back-to-back integrations with a 2-cycle gap (CAPTURE + CLEAR).
  - continuous_i=0 at CAPTURE returns to IDLE.
  - abort_i also terminates continuous mode.
  - Unacknowledged results overwrite and set overrun_o.
- Not defined: port absent; every integration needs its own start_i.

Decomposition:
- Package agc_probit_pkg holds:
  - state enum (IDLE, CLEAR, RUN, CAPTURE);
  - localparams PROBIT_LANES=8 and default NBITS/NCLK_BITS;
  - a function deriving NCLK_BITS from NBITS (NBITS-1-log2(8)).
- One sub-module is natural: agc_probit_period_counter (loadable down-counter with a zero flag). The rest is a single FSM.

Test Plan:
- period_i=3, start at t0 → acc_rst_o=1 at t0+1; acc_ce_o=1 for t0+2..t0+5 (4 cycles); valid_o=1 at t0+7. Model accumulator with all lanes gt=1, lt=0 → gt_count_o=32, lt_count_o=0.
- period_i=0 → exactly one acc_ce_o cycle; gt_count_o=8 with all-ones gt.
- Abort at RUN cycle 2 of period 9 → acc_ce_o drops next clock, valid_o stays 0, prior counts unchanged; a following start with period_i=1 behaves normally.
- Two integrations without ack → overrun_o=1 and counts = second result. ack_i during the second CAPTURE → overrun_o=0 and valid_o=1.
- rst_i asserted mid-RUN (period 100, cycle 40) → next clock all outputs at reset values, acc_rst_o=1, start ignored while busy. Max period_i=2^17-1 with all-ones gt → gt_count_o=2^20, no wrap.
- With PROBIT_SEQ_AUTORESTART_EN, continuous_i=1, period_i=3 → acc_ce_o pattern of 4 on / 2 off repeating; valid_o pulses each period; abort_i stops it.
